// File: rtl/sc_sqrt_sched.sv
// Round-robin front end that time-shares one stochastic square-root core:
// binary operand -> LFSR-compared bitstream -> clear/warm-up/measure -> ones count.
module sc_sqrt_sched #(
   parameter int WIDTH  = 6,
   parameter int NREQ   = 4,
   parameter int WARMUP = 32
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic [NREQ-1:0]          req_valid,
   output logic [NREQ-1:0]          req_ready,
   input  logic [NREQ*WIDTH-1:0]    req_data,
   output logic                     rsp_valid,
   input  logic                     rsp_ready,
   output logic [WIDTH-1:0]         rsp_data,
   output logic [$clog2(NREQ)-1:0]  rsp_id,
   output logic                     core_clr,
   output logic                     core_en,
   output logic                     core_in,
   output logic [WIDTH-1:0]         core_rand,
   input  logic                     core_out
);

   localparam int IDW = $clog2(NREQ);
   localparam int LEN = 1 << WIDTH;
   // Fibonacci taps: x^6+x^5+1 or x^8+x^6+x^5+x^4+1
   localparam logic [7:0] TAPS = (WIDTH == 8) ? 8'hB8 : 8'h30;

   typedef enum logic [2:0] {IDLE, CLEAR, WARM, RUN, DONE} state_t;

   state_t           state_q, state_d;
   logic [7:0]       phase_q, phase_d;
   logic [WIDTH:0]   cnt_q, cnt_d;
   logic [WIDTH-1:0] op_q, op_d;
   logic [IDW-1:0]   id_q, id_d;
   logic [IDW-1:0]   ptr_q, ptr_d;
   logic [WIDTH-1:0] lfsr_a_q, lfsr_b_q;
   logic [IDW-1:0]   gnt, sel;
   logic             gnt_vld;

   function automatic logic [WIDTH-1:0] lfsr_step(input logic [WIDTH-1:0] s);
      return {s[WIDTH-2:0], ^(s & TAPS[WIDTH-1:0])};
   endfunction

   // Walk offsets from the far end down so the nearest valid at/after ptr wins.
   always_comb begin
      gnt_vld = 1'b0;
      gnt     = '0;
      sel     = '0;
      for (int k = NREQ - 1; k >= 0; k--) begin
         sel = IDW'((int'(ptr_q) + k) % NREQ);
         if (req_valid[sel]) begin
            gnt_vld = 1'b1;
            gnt     = sel;
         end
      end
   end

   always_comb begin
      req_ready = '0;
      if (state_q == IDLE && gnt_vld) req_ready[gnt] = 1'b1;
   end

   assign core_clr  = (state_q == CLEAR);
   assign core_en   = (state_q == WARM) || (state_q == RUN);
   assign core_in   = core_en & (op_q > lfsr_a_q);
   assign core_rand = lfsr_b_q;
   assign rsp_valid = (state_q == DONE);
   assign rsp_data  = (cnt_q == (WIDTH+1)'(LEN)) ? '1 : cnt_q[WIDTH-1:0];
   assign rsp_id    = id_q;

   always_comb begin
      state_d = state_q;
      phase_d = phase_q;
      cnt_d   = cnt_q;
      op_d    = op_q;
      id_d    = id_q;
      ptr_d   = ptr_q;
      case (state_q)
         IDLE: if (gnt_vld) begin
            op_d    = req_data[int'(gnt)*WIDTH +: WIDTH];
            id_d    = gnt;
            ptr_d   = (int'(gnt) == NREQ - 1) ? '0 : gnt + 1'b1;
            state_d = CLEAR;
         end
         CLEAR: begin
            cnt_d   = '0;
            phase_d = '0;
            state_d = WARM;
         end
         WARM: begin
            phase_d = phase_q + 8'd1;
            if (phase_q == 8'(WARMUP - 1)) begin
               phase_d = '0;
               state_d = RUN;
            end
         end
         RUN: begin
            cnt_d   = cnt_q + (WIDTH+1)'(core_out);
            phase_d = phase_q + 8'd1;
            if (phase_q == 8'(LEN - 1)) state_d = DONE;
         end
         DONE: if (rsp_ready) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= IDLE;
         phase_q  <= '0;
         cnt_q    <= '0;
         op_q     <= '0;
         id_q     <= '0;
         ptr_q    <= '0;
         lfsr_a_q <= WIDTH'(1);
         lfsr_b_q <= '1;
      end else begin
         state_q <= state_d;
         phase_q <= phase_d;
         cnt_q   <= cnt_d;
         op_q    <= op_d;
         id_q    <= id_d;
         ptr_q   <= ptr_d;
         // Sources free-run across jobs; only core_en advances them.
         if (core_en) begin
            lfsr_a_q <= lfsr_step(lfsr_a_q);
            lfsr_b_q <= lfsr_step(lfsr_b_q);
         end
      end
   end

endmodule

// File: tb/tb_sc_sqrt_sched.sv
// Bench for sc_sqrt_sched: cycle-timeline reference model checked every cycle,
// plus directed jobs with hand-computed results.
module tb_sc_sqrt_sched;

   localparam int W   = 6;
   localparam int N   = 4;
   localparam int WU  = 32;
   localparam int L   = 64;
   localparam int IDW = 2;

   logic           clk = 1'b0;
   logic           rst_n = 1'b0;
   logic [N-1:0]   req_valid = '0;
   logic [N-1:0]   req_ready;
   logic [N*W-1:0] req_data = '0;
   logic           rsp_valid;
   logic           rsp_ready = 1'b1;
   logic [W-1:0]   rsp_data;
   logic [IDW-1:0] rsp_id;
   logic           core_clr, core_en, core_in, core_out;
   logic [W-1:0]   core_rand;

   sc_sqrt_sched #(.WIDTH(W), .NREQ(N), .WARMUP(WU)) dut (
      .clk(clk), .rst_n(rst_n),
      .req_valid(req_valid), .req_ready(req_ready), .req_data(req_data),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_id(rsp_id),
      .core_clr(core_clr), .core_en(core_en), .core_in(core_in),
      .core_rand(core_rand), .core_out(core_out)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   // Core stand-in: 0 = tied low, 1 = tied high, 2 = behavioural sqrt core
   // (counter climbs on input ones, falls on y&y_prev, so y^2 tracks x).
   int             core_mode = 0;
   logic [W+1:0]   bc_q;
   logic           bc_yp;
   logic           bc_y;

   function automatic logic [W+1:0] bc_next(input logic [W+1:0] c, input logic x, input logic d);
      int v;
      v = int'(c) + int'(x) - int'(d);
      if (v < 0) v = 0;
      if (v > (1 << (W + 2)) - 1) v = (1 << (W + 2)) - 1;
      return (W+2)'(v);
   endfunction

   assign bc_y     = bc_q[W+1:2] > core_rand;
   assign core_out = (core_mode == 2) ? bc_y : (core_mode == 1);

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         bc_q  <= (W+2)'(1 << (W + 1));
         bc_yp <= 1'b0;
      end else if (core_clr) begin
         bc_q  <= (W+2)'(1 << (W + 1));
         bc_yp <= 1'b0;
      end else if (core_en) begin
         bc_q  <= bc_next(bc_q, core_in, bc_y & bc_yp);
         bc_yp <= bc_y;
      end
   end

   // Per-job activity counters
   int tot_clr = 0, tot_en = 0, job_en = 0, job_in63 = 0;
   initial forever begin
      @(negedge clk);
      if (core_clr) begin
         tot_clr++;
         job_en   = 0;
         job_in63 = 0;
      end
      if (core_en) begin
         tot_en++;
         if (job_en < 63 && core_in) job_in63++;
         job_en++;
      end
   end

   // Reference model: a job is a timeline counted from the handshake cycle.
   function automatic int lfsr6(input int s);
      return ((s << 1) | (((s >> 5) ^ (s >> 4)) & 1)) & 63;
   endfunction

   bit           m_busy = 0;
   int           m_t = 0, m_op = 0, m_id = 0, m_ptr = 0, m_cnt = 0, m_a = 1, m_b = 63;
   logic [2*N-1:0] rot2;
   int           g, e_ready;
   bit           e_clr, e_en, e_run, e_valid, e_in;

   initial forever begin
      @(negedge clk);
      if (!rst_n) begin
         m_busy = 0; m_ptr = 0; m_a = 1; m_b = 63; m_cnt = 0;
         check("rst_rsp_valid", int'(rsp_valid), 0);
         check("rst_core_en", int'(core_en), 0);
         check("rst_core_clr", int'(core_clr), 0);
         check("rst_core_in", int'(core_in), 0);
         check("rst_core_rand", int'(core_rand), 63);
      end else begin
         e_clr   = m_busy && m_t == 1;
         e_en    = m_busy && m_t >= 2 && m_t <= WU + L + 1;
         e_run   = m_busy && m_t >= WU + 2 && m_t <= WU + L + 1;
         e_valid = m_busy && m_t >= WU + L + 2;
         e_in    = e_en && (m_op > m_a);
         g = -1;
         if (!m_busy) begin
            rot2 = {req_valid, req_valid} >> m_ptr;
            for (int k = N - 1; k >= 0; k--) if (rot2[k]) g = (k + m_ptr) % N;
         end
         e_ready = (g >= 0) ? (1 << g) : 0;
         check("req_ready", int'(req_ready), e_ready);
         check("core_clr", int'(core_clr), int'(e_clr));
         check("core_en", int'(core_en), int'(e_en));
         check("core_in", int'(core_in), int'(e_in));
         check("core_rand", int'(core_rand), m_b);
         check("rsp_valid", int'(rsp_valid), int'(e_valid));
         if (e_valid) begin
            check("rsp_data", int'(rsp_data), (m_cnt == L) ? L - 1 : m_cnt);
            check("rsp_id", int'(rsp_id), m_id);
         end
         if (g >= 0) begin
            m_busy = 1; m_t = 1; m_cnt = 0; m_id = g;
            m_op   = int'(req_data[g*W +: W]);
            m_ptr  = (g + 1) % N;
         end else if (m_busy) begin
            if (e_run && core_out) m_cnt++;
            if (e_en) begin
               m_a = lfsr6(m_a);
               m_b = lfsr6(m_b);
            end
            if (e_valid && rsp_ready) m_busy = 0;
            else m_t++;
         end
      end
   end

   // Submit one job from requester rid and wait for its response.
   task automatic job(input int rid, input int op, input bit rdy,
                      output int lat, output int data, output int id);
      bit ok, got;
      ok = 0; got = 0;
      req_data[rid*W +: W] = W'(op);
      req_valid = '0;
      req_valid[rid] = 1'b1;
      rsp_ready = rdy;
      for (int i = 0; i < 50 && !ok; i++) begin
         @(negedge clk);
         if (req_ready[rid]) ok = 1;
      end
      if (!ok) check("hs_timeout", 0, 1);
      @(posedge clk); #1;
      req_valid = '0;
      lat = 0;
      while (!got && lat < 400) begin
         @(negedge clk);
         lat++;
         if (rsp_valid) got = 1;
      end
      if (!got) check("rsp_timeout", 0, 1);
      data = int'(rsp_data);
      id   = int'(rsp_id);
   endtask

   int lat, d, id, c0, e0, nvalid;
   int rr_ids[5];
   int exp_rr[5] = '{0, 1, 2, 3, 0};
   bit got;

   initial begin
      repeat (2) @(posedge clk);
      #1;
      check("reset_rsp_valid", int'(rsp_valid), 0);
      check("reset_rsp_data", int'(rsp_data), 0);
      check("reset_rsp_id", int'(rsp_id), 0);
      check("reset_core_rand", int'(core_rand), 63);
      check("reset_req_ready", int'(req_ready), 0);
      rst_n = 1'b1;
      @(posedge clk); #1;

      // Tied-high core: saturated result, latency, clear/enable widths
      core_mode = 1;
      c0 = tot_clr; e0 = tot_en;
      job(0, 10, 1, lat, d, id);
      check("latency", lat, 98);
      check("sat_data", d, 63);
      check("sat_id", id, 0);
      check("clr_cycles", tot_clr - c0, 1);
      check("en_cycles", tot_en - e0, 96);
      @(posedge clk); #1;

      // Tied-low core and input-stream densities
      core_mode = 0;
      job(1, 32, 1, lat, d, id);
      check("zero_data", d, 0);
      check("zero_id", id, 1);
      check("ones_op32", job_in63, 31);
      check("job_en", job_en, 96);
      @(posedge clk); #1;
      job(2, 0, 1, lat, d, id);
      check("ones_op0", job_in63, 0);
      @(posedge clk); #1;
      job(3, 63, 1, lat, d, id);
      check("ones_op63", job_in63, 62);
      check("id3", id, 3);
      @(posedge clk); #1;

      // Round robin with all requesters asserted
      req_data  = {N{W'(5)}};
      req_valid = '1;
      rsp_ready = 1'b1;
      for (int r = 0; r < 5; r++) begin
         got = 0;
         for (int i = 0; i < 200 && !got; i++) begin
            @(negedge clk);
            if (rsp_valid) got = 1;
         end
         if (!got) check("rr_timeout", 0, 1);
         rr_ids[r] = int'(rsp_id);
         @(posedge clk); #1;
      end
      req_valid = '0;
      for (int r = 0; r < 5; r++) check("rr_order", rr_ids[r], exp_rr[r]);

      // ptr=1, only requester 2 valid: immediate grant, then backpressure
      core_mode = 1;
      req_data[2*W +: W] = W'(7);
      req_valid = 4'b0100;
      rsp_ready = 1'b0;
      @(negedge clk);
      check("gnt_imm", int'(req_ready), 4);
      @(posedge clk); #1;
      req_valid = '0;
      got = 0;
      for (int i = 0; i < 200 && !got; i++) begin
         @(negedge clk);
         if (rsp_valid) got = 1;
      end
      if (!got) check("bp_timeout", 0, 1);
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         check("bp_valid", int'(rsp_valid), 1);
         check("bp_data", int'(rsp_data), 63);
         check("bp_id", int'(rsp_id), 2);
         check("bp_en", int'(core_en), 0);
      end
      @(posedge clk); #1;
      rsp_ready = 1'b1;
      @(posedge clk); #1;
      check("rel_idle", int'(rsp_valid), 0);

      // Reset mid-RUN, then a clean job through the behavioural core
      core_mode = 2;
      req_data[0 +: W] = W'(16);
      req_valid = 4'b0001;
      got = 0;
      for (int i = 0; i < 50 && !got; i++) begin
         @(negedge clk);
         if (req_ready[0]) got = 1;
      end
      if (!got) check("mr_timeout", 0, 1);
      @(posedge clk); #1;
      req_valid = '0;
      repeat (50) @(posedge clk);
      #1;
      check("in_run", int'(core_en), 1);
      rst_n = 1'b0;
      #1;
      check("mr_rand", int'(core_rand), 63);
      check("mr_en", int'(core_en), 0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      nvalid = 0;
      for (int i = 0; i < 120; i++) begin
         @(negedge clk);
         if (rsp_valid) nvalid++;
      end
      check("lost_job", nvalid, 0);
      @(posedge clk); #1;
      req_data[0 +: W] = W'(16);
      req_data[W +: W] = W'(16);
      req_valid = 4'b0011;
      @(negedge clk);
      check("ptr_rst", int'(req_ready), 1);
      @(posedge clk); #1;
      req_valid = '0;
      lat = 0; got = 0;
      while (!got && lat < 400) begin
         @(negedge clk);
         lat++;
         if (rsp_valid) got = 1;
      end
      if (!got) check("sq_timeout", 0, 1);
      check("sq_latency", lat, 98);
      check("sq_range", int'(rsp_data >= 26 && rsp_data <= 38), 1);
      check("sq_id", int'(rsp_id), 0);
      @(posedge clk); #1;
      repeat (3) @(posedge clk);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
